// File: rtl/hamming_pkg.sv
// Shared constants, coverage masks and helpers for the 8-bit / 12-bit Hamming codec.
// Codeword layout (MSB..LSB): {p3,p2,p1,p0,d7..d0}.
package hamming_pkg;

    localparam int DATA_W          = 8;
    localparam int CODE_W          = 12;
    localparam int SYN_W           = 4;
    localparam int MAX_CORRECTABLE = 12;

    // Encoder parity coverage over the data byte
    localparam logic [DATA_W-1:0] P0_MASK = 8'h5B;  // d0 d1 d3 d4 d6
    localparam logic [DATA_W-1:0] P1_MASK = 8'h6D;  // d0 d2 d3 d5 d6
    localparam logic [DATA_W-1:0] P2_MASK = 8'h8E;  // d1 d2 d3 d7
    localparam logic [DATA_W-1:0] P3_MASK = 8'hF0;  // d4 d5 d6 d7

    // Decoder syndrome coverage over the full received codeword
    localparam logic [CODE_W-1:0] S0_MASK = 12'h5B1;  // c0 c4 c5 c7 c8 c10
    localparam logic [CODE_W-1:0] S1_MASK = 12'h6D2;  // c1 c4 c6 c7 c9 c10
    localparam logic [CODE_W-1:0] S2_MASK = 12'h8E4;  // c2 c5 c6 c7 c11
    localparam logic [CODE_W-1:0] S3_MASK = 12'hF08;  // c3 c8 c9 c10 c11

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              error_detected;
        logic              error_corrected;
        logic [SYN_W-1:0]  syndrome;
    } dec_result_t;

    // A syndrome of k (1..12) points at codeword bit k-1; only data bits matter downstream.
    function automatic logic [DATA_W-1:0] data_flip_mask(input logic [SYN_W-1:0] syn);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (syn == SYN_W'(i + 1));
        end
        return m;
    endfunction

    function automatic logic in_correctable_range(input logic [SYN_W-1:0] syn);
        return (syn != '0) && (syn <= SYN_W'(MAX_CORRECTABLE));
    endfunction

endpackage

// File: rtl/hamming_decoder.sv
// Combinational Hamming decoder: syndrome generation, single-bit correction and error flags.
// The syndrome equations are fixed by the link partner and are not the encoder's inverse.
module hamming_decoder
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] codeword,
    output logic [DATA_W-1:0] data_out,
    output logic              error_detected,
    output logic              error_corrected,
    output logic [SYN_W-1:0]  syndrome
);

    logic [SYN_W-1:0] syn;

    assign syn[0] = ^(codeword & S0_MASK);
    assign syn[1] = ^(codeword & S1_MASK);
    assign syn[2] = ^(codeword & S2_MASK);
    assign syn[3] = ^(codeword & S3_MASK);

    assign syndrome        = syn;
    assign error_detected  = |syn;
    assign error_corrected = in_correctable_range(syn);

    // Syndromes 9..12 flip a parity bit, 13..15 are uncorrectable: data passes unchanged.
    assign data_out = codeword[DATA_W-1:0] ^ data_flip_mask(syn);

endmodule

// File: rtl/hamming_encoder.sv
// Combinational Hamming encoder: 8-bit data in, 12-bit codeword out.
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] codeword
);

    logic p0;
    logic p1;
    logic p2;
    logic p3;

    assign p0 = ^(data_in & P0_MASK);
    assign p1 = ^(data_in & P1_MASK);
    assign p2 = ^(data_in & P2_MASK);
    assign p3 = ^(data_in & P3_MASK);

    assign codeword = {p3, p2, p1, p0, data_in};

endmodule

// File: rtl/hamming_codec.sv
// Registered Hamming codec: independent one-cycle encode and decode paths
// plus saturating detect/correct statistics counters.
module hamming_codec
    import hamming_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enc_valid,
    input  logic [7:0]         enc_data,
    output logic               enc_valid_out,
    output logic [11:0]        enc_codeword,
    input  logic               dec_valid,
    input  logic [11:0]        dec_codeword,
    output logic               dec_valid_out,
    output logic [7:0]         dec_data,
    output logic               error_detected,
    output logic               error_corrected,
    output logic [3:0]         syndrome,
    output logic [COUNT_W-1:0] detect_count,
    output logic [COUNT_W-1:0] correct_count
);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt,
                                                   input logic               en);
        if (en && (cnt != '1)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

    logic [CODE_W-1:0] enc_cw_c;
    dec_result_t       dec_res_c;

    hamming_encoder u_encoder (
        .data_in  (enc_data),
        .codeword (enc_cw_c)
    );

    hamming_decoder u_decoder (
        .codeword        (dec_codeword),
        .data_out        (dec_res_c.data),
        .error_detected  (dec_res_c.error_detected),
        .error_corrected (dec_res_c.error_corrected),
        .syndrome        (dec_res_c.syndrome)
    );

    logic               enc_valid_q,  enc_valid_d;
    logic [CODE_W-1:0]  enc_cw_q,     enc_cw_d;
    logic               dec_valid_q,  dec_valid_d;
    dec_result_t        dec_res_q,    dec_res_d;
    logic [COUNT_W-1:0] det_cnt_q,    det_cnt_d;
    logic [COUNT_W-1:0] corr_cnt_q,   corr_cnt_d;

    always_comb begin
        enc_valid_d = enc_valid;
        enc_cw_d    = enc_valid ? enc_cw_c : enc_cw_q;
        dec_valid_d = dec_valid;
        dec_res_d   = dec_valid ? dec_res_c : dec_res_q;
        det_cnt_d   = det_cnt_q;
        corr_cnt_d  = corr_cnt_q;
        if (dec_valid) begin
            det_cnt_d  = sat_inc(det_cnt_q,  dec_res_c.error_detected);
            corr_cnt_d = sat_inc(corr_cnt_q, dec_res_c.error_corrected);
        end
    end

    // Output register stage: data/flags hold while the path is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_valid_q <= 1'b0;
            enc_cw_q    <= '0;
            dec_valid_q <= 1'b0;
            dec_res_q   <= '0;
            det_cnt_q   <= '0;
            corr_cnt_q  <= '0;
        end else begin
            enc_valid_q <= enc_valid_d;
            enc_cw_q    <= enc_cw_d;
            dec_valid_q <= dec_valid_d;
            dec_res_q   <= dec_res_d;
            det_cnt_q   <= det_cnt_d;
            corr_cnt_q  <= corr_cnt_d;
        end
    end

    assign enc_valid_out   = enc_valid_q;
    assign enc_codeword    = enc_cw_q;
    assign dec_valid_out   = dec_valid_q;
    assign dec_data        = dec_res_q.data;
    assign error_detected  = dec_res_q.error_detected;
    assign error_corrected = dec_res_q.error_corrected;
    assign syndrome        = dec_res_q.syndrome;
    assign detect_count    = det_cnt_q;
    assign correct_count   = corr_cnt_q;

endmodule

// File: tb/tb_hamming_codec.sv
// Scoreboard bench for hamming_codec with 2-bit counters so saturation is reachable.
module tb_hamming_codec;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enc_valid;
    logic [7:0]    enc_data;
    logic          enc_valid_out;
    logic [11:0]   enc_codeword;
    logic          dec_valid;
    logic [11:0]   dec_codeword;
    logic          dec_valid_out;
    logic [7:0]    dec_data;
    logic          error_detected;
    logic          error_corrected;
    logic [3:0]    syndrome;
    logic [CW-1:0] detect_count;
    logic [CW-1:0] correct_count;

    hamming_codec #(.COUNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .enc_valid       (enc_valid),
        .enc_data        (enc_data),
        .enc_valid_out   (enc_valid_out),
        .enc_codeword    (enc_codeword),
        .dec_valid       (dec_valid),
        .dec_codeword    (dec_codeword),
        .dec_valid_out   (dec_valid_out),
        .dec_data        (dec_data),
        .error_detected  (error_detected),
        .error_corrected (error_corrected),
        .syndrome        (syndrome),
        .detect_count    (detect_count),
        .correct_count   (correct_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    data;
        logic [3:0]    syn;
        logic          det;
        logic          corr;
        logic [CW-1:0] dcnt;
        logic [CW-1:0] ccnt;
    } dec_exp_t;

    logic [11:0]   enc_q[$];
    dec_exp_t      dec_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] m_det;
    logic [CW-1:0] m_corr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever an output is presented
    always @(negedge clk) begin
        logic [11:0] e;
        dec_exp_t    d;
        if (rst === 1'b0) begin
            if (enc_valid_out) begin
                if (enc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL enc_unexpected: got codeword 0x%0h with empty queue", enc_codeword);
                end else begin
                    e = enc_q.pop_front();
                    chk("enc_codeword", 32'(enc_codeword), 32'(e));
                end
            end
            if (dec_valid_out) begin
                if (dec_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dec_unexpected: got data 0x%0h with empty queue", dec_data);
                end else begin
                    d = dec_q.pop_front();
                    chk("dec_data",        32'(dec_data),        32'(d.data));
                    chk("syndrome",        32'(syndrome),        32'(d.syn));
                    chk("error_detected",  32'(error_detected),  32'(d.det));
                    chk("error_corrected", 32'(error_corrected), 32'(d.corr));
                    chk("detect_count",    32'(detect_count),    32'(d.dcnt));
                    chk("correct_count",   32'(correct_count),   32'(d.ccnt));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        enc_valid = 1'b0;
        dec_valid = 1'b0;
    endtask

    task automatic put_enc(input logic [7:0] d, input logic [11:0] exp_cw);
        enc_valid = 1'b1;
        enc_data  = d;
        enc_q.push_back(exp_cw);
    endtask

    task automatic put_dec(input logic [11:0] cw, input logic [7:0] exp_d,
                           input logic [3:0] exp_s, input logic exp_det, input logic exp_corr);
        dec_exp_t x;
        dec_valid    = 1'b1;
        dec_codeword = cw;
        if (exp_det  && (m_det  != '1)) m_det  = m_det  + 1'b1;
        if (exp_corr && (m_corr != '1)) m_corr = m_corr + 1'b1;
        x = '{data: exp_d, syn: exp_s, det: exp_det, corr: exp_corr, dcnt: m_det, ccnt: m_corr};
        dec_q.push_back(x);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_enc_valid_out"},   32'(enc_valid_out),   0);
        chk({tag, "_enc_codeword"},    32'(enc_codeword),    0);
        chk({tag, "_dec_valid_out"},   32'(dec_valid_out),   0);
        chk({tag, "_dec_data"},        32'(dec_data),        0);
        chk({tag, "_error_detected"},  32'(error_detected),  0);
        chk({tag, "_error_corrected"}, 32'(error_corrected), 0);
        chk({tag, "_syndrome"},        32'(syndrome),        0);
        chk({tag, "_detect_count"},    32'(detect_count),    0);
        chk({tag, "_correct_count"},   32'(correct_count),   0);
    endtask

    initial begin
        rst          = 1'b1;
        enc_valid    = 1'b0;
        enc_data     = '0;
        dec_valid    = 1'b0;
        dec_codeword = '0;
        m_det        = '0;
        m_corr       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Directed vectors; encode and decode overlap to exercise path independence
        step(); put_enc(8'h01, 12'h301);
        step(); put_enc(8'hAA, 12'h4AA); put_dec(12'h000, 8'h00, 4'd0, 1'b0, 1'b0);
        step(); put_enc(8'h00, 12'h000); put_dec(12'h4AA, 8'hAE, 4'd3, 1'b1, 1'b1);
        step(); put_dec(12'h4AB, 8'hA9, 4'd2, 1'b1, 1'b1);
        step(); put_enc(8'hFF, 12'h3FF); put_dec(12'h180, 8'h80, 4'd14, 1'b1, 1'b0);
        step(); put_enc(8'h10, 12'h910); put_dec(12'h800, 8'h00, 4'd12, 1'b1, 1'b1);
        step(); put_dec(12'h104, 8'h04, 4'd13, 1'b1, 1'b0);
        step();
        step();

        // Idle inputs: valids drop, everything else holds
        chk("hold_enc_valid_out",   32'(enc_valid_out),   0);
        chk("hold_enc_codeword",    32'(enc_codeword),    32'h910);
        chk("hold_dec_valid_out",   32'(dec_valid_out),   0);
        chk("hold_dec_data",        32'(dec_data),        32'h04);
        chk("hold_syndrome",        32'(syndrome),        13);
        chk("hold_error_detected",  32'(error_detected),  1);
        chk("hold_error_corrected", 32'(error_corrected), 0);
        chk("hold_detect_count",    32'(detect_count),    3);
        chk("hold_correct_count",   32'(correct_count),   3);

        // Reset in the middle of a burst discards in-flight words
        step(); put_dec(12'h4AA, 8'hAE, 4'd3, 1'b1, 1'b1); put_enc(8'h01, 12'h301);
        step(); put_dec(12'h180, 8'h80, 4'd14, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        enc_q.delete();
        dec_q.delete();
        m_det     = '0;
        m_corr    = '0;
        dec_valid = 1'b0;
        enc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        step();
        chk("post_rst_dec_valid_out", 32'(dec_valid_out), 0);
        chk("post_rst_enc_valid_out", 32'(enc_valid_out), 0);

        // Five detected words into 2-bit counters: both saturate at 3
        step(); put_dec(12'h4AA, 8'hAE, 4'd3,  1'b1, 1'b1);
        step(); put_dec(12'h180, 8'h80, 4'd14, 1'b1, 1'b0);
        step(); put_dec(12'h4AB, 8'hA9, 4'd2,  1'b1, 1'b1);
        step(); put_dec(12'h180, 8'h80, 4'd14, 1'b1, 1'b0);
        step(); put_dec(12'h001, 8'h00, 4'd1,  1'b1, 1'b1);
        step();
        step();
        chk("sat_detect_count",  32'(detect_count),  3);
        chk("sat_correct_count", 32'(correct_count), 3);

        for (int i = 0; i < 5; i++) begin
            if ((enc_q.size() != 0) || (dec_q.size() != 0)) @(posedge clk);
        end
        #1;
        if ((enc_q.size() != 0) || (dec_q.size() != 0)) begin
            total++; bad++;
            $display("FAIL drain: got %0d enc and %0d dec pending, expected 0", enc_q.size(), dec_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_codec.md
Name: hamming_codec

Overview:
Registered 8-bit data / 12-bit codeword Hamming codec with independent encode and decode paths. Each path has combinational core logic (hamming_encoder, hamming_decoder) followed by a one-cycle output register stage. Saturating error statistics counters are included. Sits between a data source/sink and a storage or link interface that may corrupt codewords.

Parameters:
- COUNT_W, 16, width of the saturating error statistics counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enc_valid  in  1  enc_data is valid this cycle.
- enc_data  in  8  data to encode.
- enc_valid_out  out  1  enc_codeword is valid.
- enc_codeword  out  12  encoded word.
- dec_valid  in  1  dec_codeword is valid this cycle.
- dec_codeword  in  12  received, possibly corrupted, codeword.
- dec_valid_out  out  1  decoder outputs are valid.
- dec_data  out  8  corrected data.
- error_detected  out  1  syndrome is nonzero.
- error_corrected  out  1  syndrome is in the range 1..12 and a bit was flipped.
- syndrome  out  4  raw syndrome.
- detect_count  out  COUNT_W  number of accepted words with error_detected set.
- correct_count  out  COUNT_W  number of accepted words with error_corrected set.

Behaviour:
- Codeword layout, MSB to LSB: {p3,p2,p1,p0,d7..d0}. Data occupies bits [7:0]; parity occupies bits [11:8].
- Encoder parity equations:
  - p0 = d0^d1^d3^d4^d6
  - p1 = d0^d2^d3^d5^d6
  - p2 = d1^d2^d3^d7
  - p3 = d4^d5^d6^d7
- Decoder syndrome equations (c = dec_codeword). These are normative and must be bit-exact even though they are not the inverse of the encoder:
  - s0 = c0^c4^c5^c7^c8^c10
  - s1 = c1^c4^c6^c7^c9^c10
  - s2 = c2^c5^c6^c7^c11
  - s3 = c3^c8^c9^c10^c11
  - syndrome = {s3,s2,s1,s0}
- Decode rules:
  - error_detected = |syndrome.
  - error_corrected = 1 when 1 <= syndrome <= 12.
  - When error_corrected, corrected word = c ^ (1 << (syndrome-1)); otherwise corrected word = c.
  - Syndromes 13..15: error_detected=1, error_corrected=0, data passes through uncorrected.
  - dec_data = corrected[7:0].
- Latency: exactly 1 cycle on each path.
  - enc_valid_out and dec_valid_out are the registered input valids.
  - Data and flag registers load only when the corresponding input valid is 1 and hold otherwise.
  - The two paths are fully independent; both may be active in the same cycle.
  - Back-to-back valid every cycle is supported. There is no backpressure.
- Counters:
  - Increment by 1 on each dec_valid cycle with the respective flag set.
  - Saturate at all-ones; never wrap.
  - Counter updates take effect in the same edge as the dec outputs.
- Reset: all outputs and registers go to 0 immediately on rst assertion. Reset asserted mid-stream discards in-flight words. The first valid output appears one cycle after the first valid input following reset release.

Decomposition:
- hamming_pkg holds:
  - DATA_W=8, CODE_W=12, SYN_W=4.
  - Parity coverage masks P0_MASK..P3_MASK for the encoder.
  - Syndrome masks S0_MASK..S3_MASK over codeword bits, per the equations above.
  - MAX_CORRECTABLE=12.
- Sub-modules: purely combinational hamming_encoder (data_in -> codeword) and hamming_decoder (codeword -> data_out, error_detected, error_corrected, syndrome), instantiated inside hamming_codec. The top level holds only registers and counters.

Test Plan:
- Encode 0x01 -> one cycle later enc_codeword=0x301, enc_valid_out=1. Encode 0xAA -> enc_codeword=0x4AA.
- Decode 0x000 -> dec_data=0x00, syndrome=0, error_detected=0, error_corrected=0; counters unchanged.
- Decode 0x4AA -> syndrome=3, error_detected=1, error_corrected=1, dec_data=0xAE; both counters increment.
- Decode 0x4AB (bit 0 flipped) -> syndrome=2, error_detected=1, error_corrected=1, dec_data=0xA9.
- Decode 0x180 -> syndrome=14, error_detected=1, error_corrected=0, dec_data=0x80; only detect_count increments.
- Drive COUNT_W=2 with 5 consecutive detected words -> detect_count=3 (saturated). Assert rst mid-burst -> all outputs 0 immediately. Hold dec_valid=0 -> outputs hold their previous values.
